ls191_updown_counter: RTL
=========================

// Module: ls191_updown_counter
// PURPOSE
//  Synchronous presettable up/down binary counter, 74LS191 function, one clock domain.
//  Companion to the up-only '161-style counter: provides the down-counting direction
//  for stack-pointer decrement, loop/step counters and countdown timers in the 8-bit CPU.
//  Cascadable through MAXMIN/RCOn; the cascade rules are in BEHAVIOUR.
// PARAMETERS
//  WIDTH     4    counter width in bits; must be >= 2. Default 4 matches the TTL part.
// PORTS
//  CLK     in   1      clock, all state changes on rising edge
//  CLRn    in   1      reset, asynchronous, active-low; forces Q=0
//  LDn     in   1      synchronous parallel load, active-low
//  CTENn   in   1      count enable, active-low
//  DUn     in   1      direction: 0 = up, 1 = down
//  D       in   WIDTH  parallel load data
//  Q       out  WIDTH  counter state
//  MAXMIN  out  1      terminal-count flag for the current direction
//  RCOn    out  1      ripple carry/borrow out, active-low, for cascading
// BEHAVIOUR
//  - Reset: CLRn=0 -> Q=0 immediately, independent of CLK. Then MAXMIN=DUn (down at 0).
//    RCOn = ~(DUn & ~CTENn). Reset released mid-count: first counting edge is the first
//    CLK rising edge with CLRn=1; no partial update.
//  - Priority on each rising edge, CLRn=1: LDn=0 -> Q<=D, regardless of CTENn and DUn.
//    Else CTENn=0 & DUn=0 -> Q<=Q+1. Else CTENn=0 & DUn=1 -> Q<=Q-1. Else hold.
//  - Arithmetic is modulo 2^WIDTH; wrap is silent.
//    Up from all-ones -> 0. Down from 0 -> all-ones.
//  - MAXMIN, combinational from Q and DUn: 1 when (DUn=0 & Q=all-ones)
//    or (DUn=1 & Q=0). It does not depend on CTENn or LDn.
//  - RCOn, combinational: RCOn = ~(MAXMIN & ~CTENn). It is low for the whole cycle
//    before a wrap edge, not a clock-gated pulse.
//  - Cascade: the high stage takes CTENn_hi = RCOn_lo. All stages share CLK, CLRn and DUn.
//  - Latency: a Q update is visible 1 cycle after the sampled edge. MAXMIN/RCOn follow
//    Q, DUn and CTENn combinationally in the same cycle.
//  - DUn change with CTENn=0: the new direction applies at the next edge. No extra step
//    and no lost step. MAXMIN re-evaluates immediately.
//  - LDn=0 with CTENn=0 in the same cycle: the load wins. RCOn may still be low in that
//    cycle. Cascaded upper stages must also see LDn=0 so that they do not step.
//  - Outputs never go X after reset for any input combination of known values.
// STRUCTURE
//  - Shared package/header ls_pkg: DIR_UP=1'b0, DIR_DOWN=1'b1. The same header holds the
//    active-low control encodings used by the whole '161/'191 family.
//  - Sub-module ls191_bit: one toggle cell per bit.
//    * Function: Q_i toggles when counting is enabled and all lower bits are at 1 (up)
//      or at 0 (down). Load muxes D_i in.
//    * Structure: the top level generates WIDTH instances and the toggle-enable chain.
//  - No state machine beyond the counter register. MAXMIN and RCOn stay combinational.
// TESTING
//  1 CLRn pulse low mid-cycle with Q=4'hA -> Q=0 before the next edge; MAXMIN=1 if DUn=1.
//  2 LDn=0, D=4'h7, CTENn=0, DUn=1, one edge -> Q=7 (load wins, no decrement);
//    then LDn=1 for 3 edges -> Q=6, 5, 4.
//  3 Up from Q=4'hE, CTENn=0:
//    - Q=E: MAXMIN=0, RCOn=1.
//    - Q=F: MAXMIN=1, RCOn=0.
//    - Next edge: Q=0, RCOn=1.
//  4 Down from Q=4'h1: Q=0 with MAXMIN=1, RCOn=0 -> next edge Q=F.
//    Toggle DUn at Q=5 -> next value 6, no skipped code.
//  5 Two cascaded stages (8-bit), load 8'h00, DUn=1, one edge -> 8'hFF.
//    Load 8'h0F, DUn=0, one edge -> 8'h10.
//    Run 256 edges up -> returns to start with exactly one RCOn_hi low cycle.
//  6 CTENn=1 for 5 edges with Q=4'h3 -> Q stays 3.
//    RCOn=1 even when Q=F, DUn=0 (MAXMIN=1).

Source files
------------

// File: rtl/ls_pkg.sv
// Shared encodings for the '161/'191 counter family.
// Direction and active-low control levels, plus the per-bit terminal test.
package ls_pkg;

  localparam logic DIR_UP     = 1'b0;
  localparam logic DIR_DOWN   = 1'b1;
  localparam logic ASSERT_N   = 1'b0;
  localparam logic DEASSERT_N = 1'b1;

  // A bit is "at terminal" when it is 1 counting up or 0 counting down.
  function automatic logic tc_bit(
    input logic q,
    input logic dun
  );
    return (dun == DIR_DOWN) ? ~q : q;
  endfunction

endpackage

// File: rtl/ls191_updown_counter_bit.sv
// One toggle cell of the '191 counter.
// Load has priority over toggle; clear is asynchronous.
import ls_pkg::*;

module ls191_bit (
  input  logic i_clk,
  input  logic i_clr_n,
  input  logic i_ld_n,
  input  logic i_d,
  input  logic i_t,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_q <= 1'b0;
    end else if (i_ld_n == ASSERT_N) begin
      r_q <= i_d;
    end else if (i_t) begin
      r_q <= ~r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ls191_updown_counter.sv
// 74LS191-style presettable up/down counter.
// Built from per-bit toggle cells and a ripple toggle-enable chain.
import ls_pkg::*;

module ls191_updown_counter #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             CLRn,
  input  logic             LDn,
  input  logic             CTENn,
  input  logic             DUn,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             MAXMIN,
  output logic             RCOn
);

  logic [WIDTH-1:0] w_t;
  logic [WIDTH-1:0] w_lvl;
  logic             w_en;

  assign w_en   = (CTENn == ASSERT_N);
  assign w_t[0] = w_en;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      assign w_lvl[i] = tc_bit(Q[i], DUn);

      // Bit i toggles once every lower bit sits at its terminal level.
      if (i > 0) begin : g_chain
        assign w_t[i] = w_t[i-1] & w_lvl[i-1];
      end

      ls191_bit u_bit (
        .i_clk  (CLK),
        .i_clr_n(CLRn),
        .i_ld_n (LDn),
        .i_d    (D[i]),
        .i_t    (w_t[i]),
        .o_q    (Q[i])
      );
    end
  endgenerate

  assign MAXMIN = &w_lvl;
  assign RCOn   = ~(MAXMIN & w_en);

endmodule
